// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: during hblank picks up to SLOTS of the 4 dogs
// that cover the next line, then resolves pixel ownership from those slots.
module sprite_line_scheduler #(
  parameter int unsigned BOX_W = 48,
  parameter int unsigned BOX_H = 32,
  parameter int unsigned SLOTS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       line_start,
  input  logic [8:0] next_y,
  input  logic [9:0] posx0,
  input  logic [9:0] posx1,
  input  logic [9:0] posx2,
  input  logic [9:0] posx3,
  input  logic [8:0] posy0,
  input  logic [8:0] posy1,
  input  logic [8:0] posy2,
  input  logic [8:0] posy3,
  input  logic [9:0] px,
  input  logic       active,
  output logic       hit,
  output logic [1:0] hit_idx,
  output logic       scan_busy,
  output logic       scan_done,
  output logic       line_overflow,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state;
  logic [8:0]       y_q;
  logic [1:0]       scan_i;
  logic [2:0]       pend_cnt;
  logic             pend_ovf;
  logic [SLOTS-1:0] pend_valid;
  logic [SLOTS-1:0] act_valid;
  logic [1:0]       pend_idx [SLOTS];
  logic [1:0]       act_idx  [SLOTS];
  logic [9:0]       pend_x   [SLOTS];
  logic [9:0]       act_x    [SLOTS];

  logic [9:0] cur_x;
  logic [8:0] cur_y;
  logic       v_hit;
  logic       slot_free;
  logic       drop_now;
  logic       found;
  logic [1:0] win_idx;

  always_comb begin
    case (scan_i)
      2'd0:    begin cur_x = posx0; cur_y = posy0; end
      2'd1:    begin cur_x = posx1; cur_y = posy1; end
      2'd2:    begin cur_x = posx2; cur_y = posy2; end
      default: begin cur_x = posx3; cur_y = posy3; end
    endcase
  end

  // 10-bit compare so a box near the bottom of the 9-bit Y range does not wrap
  assign v_hit     = ({1'b0, y_q} >= {1'b0, cur_y}) &&
                     ({1'b0, y_q} <  ({1'b0, cur_y} + 10'(BOX_H)));
  assign slot_free = pend_cnt < 3'(SLOTS);
  assign drop_now  = (state == SCAN) && !line_start && v_hit && !slot_free;

  assign scan_busy = (state != IDLE);
  // a restart arriving in COMMIT aborts the commit, so the pulse is withheld
  assign scan_done = (state == COMMIT) && !line_start && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      y_q           <= '0;
      scan_i        <= '0;
      pend_cnt      <= '0;
      pend_ovf      <= 1'b0;
      pend_valid    <= '0;
      act_valid     <= '0;
      line_overflow <= 1'b0;
      for (int unsigned s = 0; s < SLOTS; s++) begin
        pend_idx[s] <= '0;
        pend_x[s]   <= '0;
        act_idx[s]  <= '0;
        act_x[s]    <= '0;
      end
    end else if (line_start) begin
      state      <= SCAN;
      y_q        <= next_y;
      scan_i     <= 2'd3;
      pend_cnt   <= '0;
      pend_ovf   <= 1'b0;
      pend_valid <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (v_hit) begin
            if (slot_free) begin
              for (int unsigned s = 0; s < SLOTS; s++) begin
                if (3'(s) == pend_cnt) begin
                  pend_valid[s] <= 1'b1;
                  pend_idx[s]   <= scan_i;
                  pend_x[s]     <= cur_x;
                end
              end
              pend_cnt <= pend_cnt + 3'd1;
            end else begin
              pend_ovf <= 1'b1;
            end
          end
          if (scan_i == 2'd0) state  <= COMMIT;
          else                scan_i <= scan_i - 2'd1;
        end
        COMMIT: begin
          act_valid     <= pend_valid;
          line_overflow <= pend_ovf;
          for (int unsigned s = 0; s < SLOTS; s++) begin
            act_idx[s] <= pend_idx[s];
            act_x[s]   <= pend_x[s];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                    drop_count <= '0;
    else if (frame_tick)                        drop_count <= {7'd0, drop_now};
    else if (drop_now && drop_count != 8'hFF)   drop_count <= drop_count + 8'd1;
  end

  // slots fill in priority order, so the first match is the highest dog index
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (!found && act_valid[s] &&
          ({1'b0, px} >= {1'b0, act_x[s]}) &&
          ({1'b0, px} <  ({1'b0, act_x[s]} + 11'(BOX_W)))) begin
        found   = 1'b1;
        win_idx = act_idx[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit     <= 1'b0;
      hit_idx <= '0;
    end else begin
      hit     <= active && found;
      hit_idx <= (active && found) ? win_idx : 2'd0;
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: driver queues expectations from a
// behavioural model, a negedge monitor compares them as the DUT responds.
module tb_sprite_line_scheduler;

  localparam int BOX_W = 48;
  localparam int BOX_H = 32;
  localparam int SLOTS = 2;

  logic       clk = 1'b0;
  logic       rst, frame_tick, line_start, active;
  logic [8:0] next_y;
  logic [9:0] px;
  logic [9:0] posx_a [4];
  logic [8:0] posy_a [4];
  logic       hit, scan_busy, scan_done, line_overflow;
  logic [1:0] hit_idx;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  sprite_line_scheduler #(.BOX_W(BOX_W), .BOX_H(BOX_H), .SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .line_start(line_start),
    .next_y(next_y),
    .posx0(posx_a[0]), .posx1(posx_a[1]), .posx2(posx_a[2]), .posx3(posx_a[3]),
    .posy0(posy_a[0]), .posy1(posy_a[1]), .posy2(posy_a[2]), .posy3(posy_a[3]),
    .px(px), .active(active), .hit(hit), .hit_idx(hit_idx),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .line_overflow(line_overflow), .drop_count(drop_count)
  );

  typedef struct { int cyc; int drop; int ovf; } sd_t;
  typedef struct { int cyc; int hit; int idx; } px_t;

  sd_t sd_q[$];
  px_t px_q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  // reference model state
  int  m_idx[$];
  int  m_x[$];
  int  m_drop = 0;
  int  sc_idx[$];
  int  sc_x[$];
  int  sc_ovf;
  int  sc_drops;

  int  ovf_pending = 0;
  int  ovf_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // dogs are examined 3 down to 0; the first SLOTS vertical hits are kept
  task automatic model_scan(input int y, input int ndogs);
    sc_idx.delete();
    sc_x.delete();
    sc_ovf = 0;
    sc_drops = 0;
    for (int k = 0; k < ndogs; k++) begin
      int d;
      d = 3 - k;
      if (y >= int'(posy_a[d]) && y < int'(posy_a[d]) + BOX_H) begin
        if (sc_idx.size() < SLOTS) begin
          sc_idx.push_back(d);
          sc_x.push_back(int'(posx_a[d]));
        end else begin
          sc_ovf = 1;
          sc_drops++;
        end
      end
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int d, input int x, input int y);
    posx_a[d] = 10'(x);
    posy_a[d] = 9'(y);
  endtask

  task automatic do_line(input int y, input bit ft);
    sd_t e;
    if (ft) m_drop = 0;
    model_scan(y, 4);
    m_drop = sat_add(m_drop, sc_drops);
    e.cyc = cyc + 5; e.drop = m_drop; e.ovf = sc_ovf;
    sd_q.push_back(e);
    line_start = 1'b1; next_y = 9'(y); frame_tick = ft;
    step();
    line_start = 1'b0; frame_tick = 1'b0;
    repeat (5) step();
    m_idx = sc_idx;
    m_x = sc_x;
  endtask

  // first line is aborted by a second line_start gap cycles later
  task automatic restart_line(input int y1, input int gap, input int y2);
    model_scan(y1, (gap - 1 > 4) ? 4 : gap - 1);
    m_drop = sat_add(m_drop, sc_drops);
    line_start = 1'b1; next_y = 9'(y1);
    step();
    line_start = 1'b0;
    repeat (gap - 1) step();
    do_line(y2, 1'b0);
  endtask

  task automatic pix(input int p, input bit act);
    px_t e;
    int  h, w;
    h = 0; w = 0;
    for (int s = 0; s < m_idx.size(); s++) begin
      if (h == 0 && p >= m_x[s] && p < m_x[s] + BOX_W) begin
        h = 1; w = m_idx[s];
      end
    end
    e.cyc = cyc + 1; e.hit = act ? h : 0; e.idx = act ? w : 0;
    px_q.push_back(e);
    px = 10'(p); active = act;
    step();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_hit"}, int'(hit), 0);
    chk({tag, "_hit_idx"}, int'(hit_idx), 0);
    chk({tag, "_scan_busy"}, int'(scan_busy), 0);
    chk({tag, "_scan_done"}, int'(scan_done), 0);
    chk({tag, "_line_overflow"}, int'(line_overflow), 0);
    chk({tag, "_drop_count"}, int'(drop_count), 0);
  endtask

  always @(negedge clk) begin
    if (ovf_pending != 0) begin
      chk("line_overflow", int'(line_overflow), ovf_exp);
      ovf_pending = 0;
    end
    if (scan_done) begin
      if (sd_q.size() == 0) begin
        chk("unexpected_scan_done", 1, 0);
      end else begin
        sd_t e;
        e = sd_q.pop_front();
        chk("scan_done_cycle", cyc, e.cyc);
        chk("drop_count", int'(drop_count), e.drop);
        ovf_exp = e.ovf;
        ovf_pending = 1;
      end
    end else if (sd_q.size() > 0 && sd_q[0].cyc < cyc) begin
      sd_t e;
      e = sd_q.pop_front();
      chk("missing_scan_done_cycle", cyc, e.cyc);
    end
    if (px_q.size() > 0 && px_q[0].cyc == cyc) begin
      px_t e;
      e = px_q.pop_front();
      chk("hit", int'(hit), e.hit);
      chk("hit_idx", int'(hit_idx), e.idx);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; line_start = 1'b0; next_y = '0;
    px = '0; active = 1'b0;
    for (int d = 0; d < 4; d++) set_pos(d, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle_zero("reset");

    // basic scheduling
    set_pos(0, 100, 50); set_pos(1, 120, 60); set_pos(2, 400, 300); set_pos(3, 600, 470);
    do_line(70, 1'b0);
    pix(110, 1); pix(130, 1); pix(167, 1); pix(168, 1);

    // overflow and frame statistics
    set_pos(0, 10, 100); set_pos(1, 200, 100); set_pos(2, 400, 100); set_pos(3, 600, 0);
    do_line(110, 1'b0);
    pix(20, 1); pix(210, 1); pix(410, 1);
    do_line(110, 1'b0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    m_drop = 0;
    chk("drop_after_frame_tick", int'(drop_count), m_drop);
    do_line(110, 1'b1);

    // vertical boundaries
    set_pos(0, 100, 100); set_pos(1, 300, 400); set_pos(2, 500, 400); set_pos(3, 700, 400);
    foreach (sc_x[i]) sc_x[i] = sc_x[i];
    do_line(99, 1'b0);  pix(120, 1);
    do_line(100, 1'b0); pix(120, 1);
    do_line(131, 1'b0); pix(120, 1);
    do_line(132, 1'b0); pix(120, 1);
    set_pos(3, 600, 470);
    do_line(479, 1'b0);

    // horizontal edge
    pix(639, 1);
    for (int p = 0; p < 8; p++) pix(p, 1);
    pix(610, 0); pix(610, 1);
    set_pos(3, 1000, 470);
    do_line(479, 1'b0);
    pix(1010, 1); pix(1023, 1); pix(5, 1);

    // restart mid-scan
    set_pos(0, 100, 50); set_pos(1, 120, 60); set_pos(2, 400, 300); set_pos(3, 600, 470);
    restart_line(70, 2, 300);
    pix(410, 1); pix(130, 1);

    // reset during SCAN
    line_start = 1'b1; next_y = 9'd70;
    step();
    line_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_idx.delete(); m_x.delete(); m_drop = 0;
    chk_idle_zero("mid_scan_reset");
    repeat (8) step();
    pix(110, 1);

    // randomized lines
    for (int it = 0; it < 60; it++) begin
      int base;
      base = $urandom_range(0, 480);
      for (int d = 0; d < 4; d++) begin
        int yy;
        yy = base + $urandom_range(0, 40);
        set_pos(d, $urandom_range(0, 1023), (yy > 511) ? 511 : yy);
      end
      if ($urandom_range(0, 4) == 0)
        restart_line($urandom_range(0, 511), $urandom_range(1, 5), base + $urandom_range(0, 50));
      else
        do_line(base + $urandom_range(0, 50), ($urandom_range(0, 7) == 0));
      for (int k = 0; k < 12; k++) begin
        int p;
        if (m_x.size() > 0 && $urandom_range(0, 2) != 0)
          p = m_x[$urandom_range(0, m_x.size() - 1)] + $urandom_range(0, 60) - 6;
        else
          p = $urandom_range(0, 1023);
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        pix(p, ($urandom_range(0, 4) != 0));
      end
    end

    repeat (10) step();
    if (sd_q.size() != 0) chk("outstanding_scan_done", sd_q.size(), 0);
    if (px_q.size() != 0) chk("outstanding_pixels", px_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite scheduler for the dog renderer; replaces brute-force four-way bounding-box compare per pixel.
- During horizontal blanking, serially evaluates all 4 dogs against the upcoming line and loads up to SLOTS hitting dogs, in priority order, into double-buffered slot registers.
- During active video, reports per pixel which scheduled dog (if any) owns the pixel.
- Sits between game_core_v8 position outputs and the pixel generation stage, clocked by pix_clk.

Parameters:
- BOX_W, 48, sprite width in pixels.
- BOX_H, 32, sprite height in lines.
- SLOTS, 2, maximum dogs displayable on one line; range 1..4.

Ports:
- clk  in  1  pixel clock (pix_clk domain).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame; clears frame statistics.
- line_start  in  1  one-cycle pulse; request scheduling of line next_y.
- next_y  in  9  line to be scheduled; sampled only on line_start.
- posx0..posx3  in  10 each  dog box X origin.
- posy0..posy3  in  9 each  dog box Y origin.
- px  in  10  current pixel X.
- active  in  1  display-active qualifier for px.
- hit  out  1  registered: pixel covered by a scheduled dog.
- hit_idx  out  2  registered: owning dog index; 0 when hit=0.
- scan_busy  out  1  high while in SCAN or COMMIT.
- scan_done  out  1  one-cycle pulse in COMMIT.
- line_overflow  out  1  more than SLOTS dogs hit the last committed line.
- drop_count  out  8  dogs dropped this frame, saturating at 255.

Behaviour:
- Reset: state IDLE; all pending and active slots invalid; hit=0, hit_idx=0, scan_busy=0, scan_done=0, line_overflow=0, drop_count=0.
- FSM: IDLE, SCAN, COMMIT.
- IDLE: on line_start, latch next_y, set scan index i=3, clear the pending list and pending overflow, then go to SCAN.
- SCAN: one dog per cycle, order 3,2,1,0. Dog 3 is highest priority and dog 0 is lowest.
  - Vertical hit: next_y >= posy_i and next_y < posy_i + BOX_H, evaluated at 10 bits so there is no wrap.
  - Hit with pending count < SLOTS: append {valid, idx=i, x=posx_i} to the next free pending slot.
  - Hit with pending list full: set pending overflow and add 1 to the cycle's drop tally.
  - After i=0, go to COMMIT.
  - Position inputs are sampled in their scan cycle and need not be stable across the scan.
- COMMIT (1 cycle): copy pending slots to active slots, copy pending overflow to line_overflow, pulse scan_done, return to IDLE.
  - New active slots are used for pixel lookup from the following cycle.
- Latency: line_start at cycle t → SCAN t+1..t+4 → COMMIT t+5 → new slots used at t+6.
- line_start while SCAN or COMMIT: abort and restart from i=3 with the new next_y. Pending data is discarded, active slots are untouched, and no scan_done is issued for the aborted scan.
- Drops counted during an aborted scan remain counted.
- Pixel lookup, registered, 1-cycle latency:
  - Slot s matches when valid and px >= x_s and px < x_s + BOX_W, evaluated at 11 bits. There is no horizontal wrap.
  - The lowest-numbered matching slot wins; by fill order this is the highest dog index.
  - hit = active and any match. hit_idx = winner idx, else 0.
  - With active=0, hit=0 and hit_idx=0.
- frame_tick clears drop_count. If drops occur in the same cycle, the result is the new-cycle drops only.
- frame_tick does not clear slots or line_overflow.
- Simultaneous frame_tick and line_start: both take effect.
- Reset mid-scan: immediate return to IDLE with all state cleared; no scan_done.

Test Plan:
1. Basic scheduling.
   - Stimulus: dog0=(100,50), dog1=(120,60), dog2=(400,300), dog3=(600,470); line_start with next_y=70.
   - Response: scan_done exactly 5 cycles later; slots {1,0}; line_overflow=0.
   - Pixel checks: px=110 → hit, idx0. px=130 → idx1 (priority). px=167 → idx1. px=168 → hit=0. Each result appears 1 cycle after px.
2. Overflow.
   - Stimulus: dogs 0,1,2 at y=100, x=10/200/400; dog3 at y=0; next_y=110.
   - Response: slots {2,1}; line_overflow=1; drop_count=1. px=20 → hit=0.
   - Follow-up: a second identical line gives drop_count=2; frame_tick gives drop_count=0.
3. Vertical boundary.
   - Stimulus: posy0=100.
   - Response: next_y=99 → no hit. next_y=100 → hit. next_y=131 → hit. next_y=132 → no hit.
   - Stimulus: posy3=470 with next_y=479.
   - Response: hit, with no 9-bit wrap artefact.
4. Horizontal edge.
   - Stimulus: posx3=600 scheduled.
   - Response: px=639 → hit, idx3. px=0..7 → hit=0. active=0 at px=610 → hit=0.
5. Restart and reset.
   - Stimulus: line_start(next_y=70), then a second line_start(next_y=300) 2 cycles later.
   - Response: exactly one scan_done, 5 cycles after the second pulse; slots {2}.
   - Stimulus: rst during SCAN.
   - Response: next cycle scan_busy=0, all outputs 0, and no scan_done.
